complex_mac_feeder: RTL and testbench
=====================================

Name: complex_mac_feeder

Overview:
Upstream driver and result collector for the pipelined complex multiply-accumulate unit. It accepts a valid/ready stream of complex operand pairs, with a last flag marking the end of each dot product, and drives the MAC's a/b/load inputs with correct pipeline alignment. It captures each finished accumulation into a small result FIFO and presents it on a valid/ready output. Because the MAC cannot stall, the feeder throttles input with a credit scheme so no result is ever dropped.

Parameters:
I_DATA_WIDTH, 32, packed complex operand width; real part in [I-1:I/2], imag part in [I/2-1:0], both signed.
O_DATA_WIDTH, 80, packed accumulator width; real part in [O-1:O/2], imag part in [O/2-1:0], both signed.
LOAD_DELAY, 6, cycles from a mac_a/mac_b register update to the cycle in which mac_load must be high for that operand's product.
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2).

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
s_valid  in  1  operand beat valid.
s_ready  out  1  feeder can accept a beat.
s_a  in  I_DATA_WIDTH  complex operand a.
s_b  in  I_DATA_WIDTH  complex operand b.
s_last  in  1  beat is the final term of the current dot product.
mac_a  out  I_DATA_WIDTH  operand a to MAC (registered).
mac_b  out  I_DATA_WIDTH  operand b to MAC (registered).
mac_load  out  1  restart accumulation (registered tag pipeline output).
mac_acc  in  O_DATA_WIDTH  MAC accumulator output.
m_valid  out  1  result available.
m_ready  in  1  downstream accepts result.
m_data  out  O_DATA_WIDTH  completed dot product {real, imag}.
busy  out  1  any dot product or result in flight.

Behaviour:
- Reset (reset==0, async): mac_a=0, mac_b=0, mac_load=0, m_valid=0, m_data=0, busy=0. Tag pipeline, FIFO, inflight counter and first-flag state are cleared. first_pending=1. s_ready is 1 once reset is released.
- Accept: a beat is accepted when s_valid && s_ready. On the accept edge, mac_a<=s_a, mac_b<=s_b. On any edge without an accept, mac_a<=0 and mac_b<=0, so idle cycles add zero product.
- First tagging: an accepted beat is tagged first=first_pending, last=s_last. After an accept with s_last=1, first_pending<=1. After any other accept, first_pending<=0.
- Tag pipeline: stage 0 is written alongside mac_a/mac_b (tags are 0 on non-accept edges). Stage k holds the stage-0 tags delayed k cycles, through stage LOAD_DELAY+1.
- mac_load is high exactly when the stage LOAD_DELAY first tag is 1, so the MAC discards old acc on that beat's product.
- Capture: when the stage LOAD_DELAY+1 last tag is 1, push mac_acc into the FIFO on that edge.
- A single-beat vector (first and last both set) is legal. Back-to-back vectors with no gap are legal.
- Credit: inflight counts accepted last beats not yet pushed into the FIFO.
- s_ready = (fifo_count + inflight) < FIFO_DEPTH, combinational from registered state. It gates all beats.
- Accepting a last beat and pushing to the FIFO on the same edge leaves inflight unchanged.
- FIFO: m_valid = (fifo_count != 0); m_data = head entry, registered/FWFT. Pop on m_valid && m_ready.
- Simultaneous push and pop is legal and keeps the count. When the FIFO is full, no push can occur by construction; an assertion checks this.
- Results leave in acceptance order.
- busy = inflight!=0 || fifo_count!=0 || first_pending==0.
- Reset mid-vector: the partial vector is discarded and no result is produced for it. The next accepted beat is tagged first, so stale MAC acc is flushed by load.
- Arithmetic: none in the feeder; values pass bit-exact. The expected result is sum(a_k*b_k) per component in two's complement, truncated to O_DATA_WIDTH/2 bits.

Test Plan:
- Reset check -> all outputs 0 during reset; s_ready=1 and busy=0 the cycle after release.
- Two-beat vector a=(1,2),b=(3,4); a=(2,-1),b=(1,1), driven into an ideal LOAD_DELAY MAC model -> mac_load pulses once, LOAD_DELAY cycles after the first mac_a update; m_data real=-2, imag=11 after LOAD_DELAY+2 cycles from last accept.
- Back-to-back single-beat vectors (1,0)*(5,0) then (0,1)*(0,1) with m_ready=1 -> results (5,0) then (-1,0) in order; mac_load high on two consecutive cycles.
- m_ready=0 while streaming 6 single-beat vectors, FIFO_DEPTH=4 -> s_ready drops after the 4th accept; no result is lost; releasing m_ready delivers all 6 results in order.
- Gapped vector: beats separated by 3 idle cycles -> mac_a/mac_b are 0 in the gaps and the result is unchanged.
- Reset asserted mid-vector (after 2 of 4 beats), then a new 1-beat vector (3,0)*(2,0) -> only result (6,0) appears.

Source files
------------

// File: rtl/complex_mac_feeder.sv
// complex_mac_feeder: valid/ready front end and result collector for a
// pipelined complex multiply-accumulate unit that cannot stall.
//   clk, reset      clock, asynchronous active-low reset
//   s_valid/s_ready operand stream handshake; s_a/s_b packed {re, im}; s_last ends a dot product
//   mac_a/mac_b     registered operands to the MAC (zero on idle cycles)
//   mac_load        restart accumulation, aligned LOAD_DELAY cycles after the first operand
//   mac_acc         MAC accumulator {re, im}
//   m_valid/m_ready result stream handshake; m_data is the FIFO head
//   busy            a dot product is open or a result is in flight/queued
module complex_mac_feeder #(
  parameter int unsigned I_DATA_WIDTH = 32,
  parameter int unsigned O_DATA_WIDTH = 80,
  parameter int unsigned LOAD_DELAY   = 6,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [I_DATA_WIDTH-1:0] s_a,
  input  logic [I_DATA_WIDTH-1:0] s_b,
  input  logic                    s_last,
  output logic [I_DATA_WIDTH-1:0] mac_a,
  output logic [I_DATA_WIDTH-1:0] mac_b,
  output logic                    mac_load,
  input  logic [O_DATA_WIDTH-1:0] mac_acc,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [O_DATA_WIDTH-1:0] m_data,
  output logic                    busy
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned FIRST_N = LOAD_DELAY + 1;
  localparam int unsigned LAST_N  = LOAD_DELAY + 2;

  logic [I_DATA_WIDTH-1:0]                  mac_a_q, mac_a_d;
  logic [I_DATA_WIDTH-1:0]                  mac_b_q, mac_b_d;
  logic [FIRST_N-1:0]                       first_q, first_d;
  logic [LAST_N-1:0]                        last_q, last_d;
  logic                                     first_pending_q, first_pending_d;
  logic [CNT_W-1:0]                         inflight_q, inflight_d;
  logic [FIFO_DEPTH-1:0][O_DATA_WIDTH-1:0]  mem_q, mem_d;
  logic [PTR_W-1:0]                         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                         fifo_cnt_q, fifo_cnt_d;
  logic [O_DATA_WIDTH-1:0]                  m_data_q, m_data_d;
  logic                                     m_valid_q, m_valid_d;
  logic                                     busy_q, busy_d;

  logic accept;
  logic push;
  logic pop;

  // Credit check: every accepted last beat reserves one FIFO slot until it lands.
  assign s_ready = (SUM_W'(fifo_cnt_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
  assign accept  = s_valid && s_ready;
  // The last tag reaches the end of the pipe one cycle after its product is in mac_acc.
  assign push    = last_q[LAST_N-1];
  assign pop     = m_valid_q && m_ready;

  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_load = first_q[LOAD_DELAY];
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign busy     = busy_q;

  // Next-state logic for operands, tags, credits and the result FIFO.
  always_comb begin
    mac_a_d         = '0;
    mac_b_d         = '0;
    first_d         = first_q << 1;
    last_d          = last_q << 1;
    first_pending_d = first_pending_q;
    inflight_d      = inflight_q;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    fifo_cnt_d      = fifo_cnt_q;

    if (accept) begin
      mac_a_d         = s_a;
      mac_b_d         = s_b;
      first_d[0]      = first_pending_q;
      last_d[0]       = s_last;
      first_pending_d = s_last;
    end

    // A last beat accepted on the same edge as a push leaves the credit count as is.
    unique case ({accept && s_last, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = mac_acc;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // Head entry is registered so m_data comes straight from a flop.
    m_data_d  = mem_d[rd_ptr_d];
    m_valid_d = (fifo_cnt_d != '0);
    busy_d    = (inflight_d != '0) || (fifo_cnt_d != '0) || !first_pending_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_a_q         <= '0;
      mac_b_q         <= '0;
      first_q         <= '0;
      last_q          <= '0;
      first_pending_q <= 1'b1;
      inflight_q      <= '0;
      mem_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      mac_a_q         <= mac_a_d;
      mac_b_q         <= mac_b_d;
      first_q         <= first_d;
      last_q          <= last_d;
      first_pending_q <= first_pending_d;
      inflight_q      <= inflight_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
      m_data_q        <= m_data_d;
      m_valid_q       <= m_valid_d;
      busy_q          <= busy_d;
    end
  end

  // The credit scheme guarantees a free slot for every push.
  no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_complex_mac_feeder.sv
// Directed bench for complex_mac_feeder, with an ideal LOAD_DELAY complex MAC
// attached to the mac_* ports.
module tb_complex_mac_feeder;

  localparam int unsigned IW = 32;
  localparam int unsigned OW = 80;
  localparam int unsigned LD = 6;
  localparam int unsigned FD = 4;
  localparam int unsigned HW = IW / 2;
  localparam int unsigned OH = OW / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid, s_ready, s_last;
  logic [IW-1:0] s_a, s_b, mac_a, mac_b;
  logic          mac_load;
  logic [OW-1:0] mac_acc;
  logic          m_valid, m_ready, busy;
  logic [OW-1:0] m_data;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  complex_mac_feeder #(
    .I_DATA_WIDTH(IW), .O_DATA_WIDTH(OW), .LOAD_DELAY(LD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_load(mac_load), .mac_acc(mac_acc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] pk_in(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic logic [OW-1:0] pk_out(input int re, input int im);
    return {40'(re), 40'(im)};
  endfunction

  function automatic logic [OW-1:0] cmul(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic signed [OH-1:0] ar, ai, br, bi;
    ar = OH'($signed(a[IW-1:HW]));
    ai = OH'($signed(a[HW-1:0]));
    br = OH'($signed(b[IW-1:HW]));
    bi = OH'($signed(b[HW-1:0]));
    return {ar * br - ai * bi, ar * bi + ai * br};
  endfunction

  function automatic logic [OW-1:0] cadd(input logic [OW-1:0] x, input logic [OW-1:0] y);
    return {x[OW-1:OH] + y[OW-1:OH], x[OH-1:0] + y[OH-1:0]};
  endfunction

  // Ideal MAC: never reset, so only mac_load can clear its stale starting value.
  logic [OW-1:0] pd [LD] = '{default: '0};
  logic [OW-1:0] acc = {40'h00000BAD00, 40'h0000001234};
  assign mac_acc = acc;
  always @(posedge clk) begin
    pd[0] <= cmul(mac_a, mac_b);
    for (int k = 1; k < LD; k++) pd[k] <= pd[k-1];
    acc <= mac_load ? pd[LD-1] : cadd(acc, pd[LD-1]);
  end

  // Record delivered results and mac_load cycles.
  logic [OW-1:0] got_q [$];
  int            load_q [$];
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
    if (rst_n && mac_load) load_q.push_back(cyc);
  end

  function automatic logic [OW-1:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 'x;
  endfunction

  function automatic int load_at(input int i);
    return (load_q.size() > i) ? load_q[i] : -1;
  endfunction

  task automatic chk(input logic [OW-1:0] obs, input logic [OW-1:0] exp, input string tag);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input logic obs, input logic exp, input string tag);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input int obs, input int exp, input string tag);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat and return the cycle number of its accept edge.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input logic last, output int c);
    logic ok;
    ok = 1'b0;
    c = -1;
    s_valid = 1'b1;
    s_a = pk_in(ar, ai);
    s_b = pk_in(br, bi);
    s_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_bit(ok, 1'b1, "accept_timeout");
    if (ok) begin
      @(posedge clk);
      #1;
      c = cyc;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    s_a = '0;
    s_b = '0;
  endtask

  task automatic wait_got(input int n, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
    chk_int(got_q.size(), n, tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk_bit(busy, 1'b0, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1, c, base, lbase, rcyc;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk(OW'(mac_a), '0, "rst_mac_a");
    chk(OW'(mac_b), '0, "rst_mac_b");
    chk_bit(mac_load, 1'b0, "rst_mac_load");
    chk_bit(m_valid, 1'b0, "rst_m_valid");
    chk(m_data, '0, "rst_m_data");
    chk_bit(busy, 1'b0, "rst_busy");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_bit(s_ready, 1'b1, "post_rst_s_ready");
    chk_bit(busy, 1'b0, "post_rst_busy");
    @(posedge clk);
    #1;

    // Two-beat vector: (1,2)*(3,4) + (2,-1)*(1,1) = (-2,11)
    m_ready = 1'b1;
    lbase = load_q.size();
    send(1, 2, 3, 4, 1'b0, c0);
    chk(OW'(mac_a), OW'(pk_in(1, 2)), "t2_mac_a");
    chk(OW'(mac_b), OW'(pk_in(3, 4)), "t2_mac_b");
    send(2, -1, 1, 1, 1'b1, c1);
    rcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid) begin
        rcyc = cyc;
        break;
      end
    end
    chk_int(rcyc, c1 + LD + 2, "t2_result_latency");
    chk(m_data, pk_out(-2, 11), "t2_m_data");
    wait_idle("t2_idle");
    chk_int(load_q.size() - lbase, 1, "t2_load_count");
    chk_int(load_at(lbase), c0 + LD, "t2_load_cycle");

    // Back-to-back single-beat vectors
    lbase = load_q.size();
    base = got_q.size();
    send(1, 0, 5, 0, 1'b1, c0);
    send(0, 1, 0, 1, 1'b1, c1);
    chk_int(c1, c0 + 1, "t3_back_to_back");
    wait_got(base + 2, "t3_count");
    chk(got_at(base), pk_out(5, 0), "t3_res0");
    chk(got_at(base + 1), pk_out(-1, 0), "t3_res1");
    chk_int(load_at(lbase), c0 + LD, "t3_load0");
    chk_int(load_at(lbase + 1), c0 + LD + 1, "t3_load1");
    wait_idle("t3_idle");

    // Backpressure: 6 single-beat vectors (k+1,0)*(2,1) = (2k+2, k+1)
    m_ready = 1'b0;
    base = got_q.size();
    for (int k = 0; k < 4; k++) send(k + 1, 0, 2, 1, 1'b1, c);
    chk_bit(s_ready, 1'b0, "t4_s_ready_drop");
    repeat (20) @(negedge clk);
    chk_bit(s_ready, 1'b0, "t4_s_ready_held");
    chk_bit(m_valid, 1'b1, "t4_m_valid");
    chk(m_data, pk_out(2, 1), "t4_head");
    chk_int(got_q.size(), base, "t4_no_pop");
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int k = 4; k < 6; k++) send(k + 1, 0, 2, 1, 1'b1, c);
    wait_got(base + 6, "t4_count");
    for (int k = 0; k < 6; k++) chk(got_at(base + k), pk_out(2 * k + 2, k + 1), "t4_order");
    wait_idle("t4_idle");

    // Gapped vector: (1,1)*(2,0) + (0,2)*(1,-1) + (3,0)*(1,1) = (7,7)
    base = got_q.size();
    send(1, 1, 2, 0, 1'b0, c);
    @(posedge clk);
    #1;
    chk(OW'(mac_a), '0, "t5_gap1_a");
    chk(OW'(mac_b), '0, "t5_gap1_b");
    repeat (2) @(posedge clk);
    #1;
    send(0, 2, 1, -1, 1'b0, c);
    @(posedge clk);
    #1;
    chk(OW'(mac_a), '0, "t5_gap2_a");
    chk(OW'(mac_b), '0, "t5_gap2_b");
    repeat (2) @(posedge clk);
    #1;
    send(3, 0, 1, 1, 1'b1, c);
    wait_got(base + 1, "t5_count");
    chk(got_at(base), pk_out(7, 7), "t5_result");
    wait_idle("t5_idle");

    // Reset after 2 of 4 beats, then (3,0)*(2,0) = (6,0)
    base = got_q.size();
    send(7, 7, 7, 7, 1'b0, c);
    send(7, 7, 7, 7, 1'b0, c);
    @(negedge clk);
    chk_bit(busy, 1'b1, "t6_busy_open");
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk(OW'(mac_a), '0, "t6_rst_mac_a");
    chk_bit(busy, 1'b0, "t6_rst_busy");
    chk_bit(m_valid, 1'b0, "t6_rst_m_valid");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3, 0, 2, 0, 1'b1, c);
    wait_got(base + 1, "t6_count");
    chk(got_at(base), pk_out(6, 0), "t6_result");
    repeat (30) @(negedge clk);
    chk_int(got_q.size(), base + 1, "t6_no_extra");
    wait_idle("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
